// File: rtl/apu_cmd_sequencer.sv
// Decodes nibble-encoded UART command bytes into APU square-channel register
// writes, delivered through a one-entry valid/ready holding register.
module apu_cmd_sequencer #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned TIMEOUT_US = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       restart,
  output logic       overflow,
  input  logic [2:0] shadow_rd_addr,
  output logic [7:0] shadow_rd_data
);

  localparam int unsigned TMO_CYCLES = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int unsigned CNT_W      = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYCLES > 0) ? TMO_CYCLES - 1 : 0);

  typedef enum logic {
    S_IDLE,
    S_STAGED
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_stage_addr;
  logic [3:0]       r_stage_lo;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [7:0]       r_shadow [8];
  logic [2:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_wr_valid;
  logic             r_restart;
  logic             r_overflow;

  logic [2:0] w_addr;
  logic [3:0] w_nib;
  logic       w_hi;
  logic       w_lo_load;
  logic       w_commit;
  logic [3:0] w_lo;
  logic [7:0] w_commit_data;
  logic       w_handshake;

  // Byte layout: {channel, reg[1:0], hi/lo select, nibble[3:0]}.
  assign w_addr      = {rx_data[7], rx_data[6:5]};
  assign w_hi        = rx_data[4];
  assign w_nib       = rx_data[3:0];
  assign w_lo_load   = rx_valid && !w_hi;
  assign w_commit    = rx_valid && w_hi;
  assign w_handshake = r_wr_valid && wr_ready;

  // A staged low nibble only pairs with a high nibble for the same register.
  assign w_lo = (r_state == S_STAGED && r_stage_addr == w_addr)
              ? r_stage_lo : r_shadow[w_addr][3:0];
  assign w_commit_data = {w_nib, w_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_lo_load) w_state_next = S_STAGED;
      end
      S_STAGED: begin
        if (rx_valid)                   w_state_next = w_hi ? S_IDLE : S_STAGED;
        else if (r_tmo_cnt == TMO_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The timeout counter only runs while a nibble stays staged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage_addr <= '0;
      r_stage_lo   <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      if (w_lo_load) begin
        r_stage_addr <= w_addr;
        r_stage_lo   <= w_nib;
        r_tmo_cnt    <= '0;
      end else if (r_state == S_STAGED && w_state_next == S_STAGED) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  // NOTE: the shadow array is reset because readback of 0x00 after reset is visible behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else if (w_commit) begin
      r_shadow[w_addr] <= w_commit_data;
    end
  end

  // Latest commit wins; replacing an unaccepted write marks it lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_restart  <= 1'b0;
    end else begin
      r_restart <= w_handshake && (r_wr_addr[1:0] == 2'd3);
      if (w_commit) begin
        r_wr_addr  <= w_addr;
        r_wr_data  <= w_commit_data;
        r_wr_valid <= 1'b1;
        if (r_wr_valid && !wr_ready) r_overflow <= 1'b1;
      end else if (w_handshake) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  assign wr_addr        = r_wr_addr;
  assign wr_data        = r_wr_data;
  assign wr_valid       = r_wr_valid;
  assign restart        = r_restart;
  assign overflow       = r_overflow;
  assign shadow_rd_data = r_shadow[shadow_rd_addr];

endmodule

// File: tb/tb_apu_cmd_sequencer.sv
// Directed self-checking bench for apu_cmd_sequencer with a shortened timeout
// (1 MHz, 20 us -> 20 cycles) so the expiry path runs quickly.
module tb_apu_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       restart;
  logic       overflow;
  logic [2:0] shadow_rd_addr;
  logic [7:0] shadow_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  apu_cmd_sequencer #(
    .CLK_HZ    (1000000),
    .TIMEOUT_US(20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .restart       (restart),
    .overflow      (overflow),
    .shadow_rd_addr(shadow_rd_addr),
    .shadow_rd_data(shadow_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Byte is presented for exactly one rising edge; returns 1 ns after that edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [2:0] a, input logic [7:0] d);
    check({tag, ".valid"}, 32'(wr_valid), 32'd1);
    check({tag, ".addr"},  32'(wr_addr),  32'(a));
    check({tag, ".data"},  32'(wr_data),  32'(d));
  endtask

  task automatic shadow_is(input string tag, input logic [2:0] a, input logic [7:0] d);
    shadow_rd_addr = a;
    #1;
    check(tag, 32'(shadow_rd_data), 32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    rx_data        = 8'h00;
    rx_valid       = 1'b0;
    wr_ready       = 1'b0;
    shadow_rd_addr = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.wr_valid", 32'(wr_valid), 32'd0);
    check("rst.wr_addr",  32'(wr_addr),  32'd0);
    check("rst.wr_data",  32'(wr_data),  32'd0);
    check("rst.restart",  32'(restart),  32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) shadow_is("rst.shadow", 3'(i), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step();

    // 0x27 stages lo=7 for addr1; 0x3A commits (1, 0xA7)
    send(8'h27);
    check("lo_only.no_write", 32'(wr_valid), 32'd0);
    send(8'h3A);
    expect_wr("t1", 3'd1, 8'hA7);
    shadow_is("t1.shadow1", 3'd1, 8'hA7);
    check("t1.restart", 32'(restart), 32'd0);
    step();
    expect_wr("t1.held", 3'd1, 8'hA7);
    wr_ready = 1'b1;
    step();
    check("t1.accepted", 32'(wr_valid), 32'd0);
    check("t1.no_restart", 32'(restart), 32'd0);

    // Three writes in order with wr_ready=1; restart follows the addr-3 handshake
    send(8'h02);
    send(8'h18);
    expect_wr("t2.w0", 3'd0, 8'h82);
    send(8'h4C);
    check("t2.hs0", 32'(wr_valid), 32'd0);
    send(8'h57);
    expect_wr("t2.w2", 3'd2, 8'h7C);
    send(8'h69);
    check("t2.hs2.restart", 32'(restart), 32'd0);
    send(8'h70);
    expect_wr("t2.w3", 3'd3, 8'h09);
    check("t2.pre_restart", 32'(restart), 32'd0);
    step();
    check("t2.restart_pulse", 32'(restart), 32'd1);
    check("t2.hs3", 32'(wr_valid), 32'd0);
    step();
    check("t2.restart_end", 32'(restart), 32'd0);

    // Commit in the handshake cycle keeps wr_valid high without overflow
    send(8'h1A);
    expect_wr("b2b.first", 3'd0, 8'hA2);
    send(8'h1B);
    expect_wr("b2b.second", 3'd0, 8'hB2);
    check("b2b.no_overflow", 32'(overflow), 32'd0);
    step();
    check("b2b.drained", 32'(wr_valid), 32'd0);

    // Stalled port: latest write wins and overflow sets
    wr_ready = 1'b0;
    send(8'h23);
    send(8'h39);
    expect_wr("t3.first", 3'd1, 8'h93);
    send(8'h0E);
    expect_wr("t3.lo_no_change", 3'd1, 8'h93);
    check("t3.overflow_pre", 32'(overflow), 32'd0);
    send(8'h19);
    expect_wr("t3.replaced", 3'd0, 8'h9E);
    check("t3.overflow", 32'(overflow), 32'd1);
    shadow_is("t3.shadow1", 3'd1, 8'h93);
    shadow_is("t3.shadow0", 3'd0, 8'h9E);
    step();
    expect_wr("t3.held", 3'd0, 8'h9E);
    wr_ready = 1'b1;
    step();
    check("t3.accepted", 32'(wr_valid), 32'd0);
    check("t3.overflow_sticky", 32'(overflow), 32'd1);

    // Staged nibble survives a gap shorter than the timeout
    send(8'h25);
    repeat (18) step();
    send(8'h39);
    expect_wr("tmo.within", 3'd1, 8'h95);

    // Staged nibble discarded after timeout; lo comes from shadow[1]=0x95
    send(8'h27);
    repeat (21) step();
    send(8'h39);
    expect_wr("tmo.expired", 3'd1, 8'h95);

    // Square2: addr=5, square1 shadows untouched
    send(8'hAB);
    send(8'hBC);
    expect_wr("t5.sq2", 3'd5, 8'hCB);
    shadow_is("t5.shadow5", 3'd5, 8'hCB);
    shadow_is("t5.shadow1", 3'd1, 8'h95);

    // Address mismatch uses shadow lo, and the high nibble empties the stage
    send(8'h02);
    send(8'h5F);
    expect_wr("mismatch", 3'd2, 8'hFC);
    send(8'h18);
    expect_wr("stage_cleared", 3'd0, 8'h8E);
    step();
    check("t5.drained", 32'(wr_valid), 32'd0);

    // Reset with an addr-3 write pending and the stage full
    wr_ready = 1'b0;
    send(8'h7F);
    expect_wr("t6.pending", 3'd3, 8'hF9);
    send(8'h25);
    wr_ready = 1'b1;
    reset    = 1'b1;
    #1;
    check("t6.wr_valid", 32'(wr_valid), 32'd0);
    check("t6.wr_addr",  32'(wr_addr),  32'd0);
    check("t6.wr_data",  32'(wr_data),  32'd0);
    check("t6.overflow", 32'(overflow), 32'd0);
    check("t6.restart",  32'(restart),  32'd0);
    step();
    check("t6.no_restart", 32'(restart), 32'd0);
    shadow_is("t6.shadow1", 3'd1, 8'h00);
    shadow_is("t6.shadow3", 3'd3, 8'h00);
    shadow_is("t6.shadow5", 3'd5, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    send(8'h39);
    expect_wr("t6.after", 3'd1, 8'h90);
    check("t6.after_overflow", 32'(overflow), 32'd0);
    step();
    check("t6.after_accepted", 32'(wr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
